// File: rtl/nco_clk_gen_pkg.sv
// nco_clk_gen_pkg: shared FSM state type and firmware/bench helper for the
// numerically-controlled clock generator.
package nco_clk_gen_pkg;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      QUALIFY  = 2'd1,
      RUN      = 2'd2
   } nco_state_t;

   // Phase increment giving f_out from reference f_ref with an acc_w-bit
   // accumulator, rounded to the nearest integer.
   function automatic logic [63:0] inc_for_hz(input real f_out,
                                              input real f_ref,
                                              input int unsigned acc_w);
      real scale;
      scale = 2.0 ** acc_w;
      return $unsigned(longint'(f_out / f_ref * scale));
   endfunction

endpackage

// File: rtl/nco_channel.sv
// nco_channel: one phase accumulator with shadow/active increment pair.
// The shadow increment is handed to the active register only on a carry
// while running, so a retune never produces a shortened output period.
module nco_channel
   import nco_clk_gen_pkg::*;
#(
   parameter int unsigned ACC_W = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             en,
   input  logic             sync,
   input  logic             wr,
   input  logic [ACC_W-1:0] wr_inc,
   output logic             pending,
   output logic             tick,
   output logic             sq
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] inc_act;
   logic [ACC_W-1:0] inc_shd;
   logic [ACC_W:0]   sum;
   logic             adding;
   logic             carry;

   assign adding = run & en;
   assign sum    = {1'b0, acc} + {1'b0, inc_act};
   assign carry  = sum[ACC_W];
   assign sq     = acc[ACC_W-1];

   // Accumulate while running and enabled; clear when not running; hold when disabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc  <= '0;
         tick <= 1'b0;
      end else if (!run) begin
         acc  <= '0;
         tick <= 1'b0;
      end else if (!en) begin
         tick <= 1'b0;
      end else if (sync) begin
         acc  <= '0;
         tick <= 1'b0;
      end else begin
         acc  <= sum[ACC_W-1:0];
         tick <= carry;
      end
   end

   // Capture writes into the shadow; promote to active when idle or on a carry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inc_act <= '0;
         inc_shd <= '0;
         pending <= 1'b0;
      end else if (wr) begin
         inc_shd <= wr_inc;
         pending <= 1'b1;
      end else if (pending && (!adding || carry)) begin
         inc_act <= inc_shd;
         pending <= 1'b0;
      end
   end

endmodule

// File: rtl/nco_clk_gen.sv
// nco_clk_gen: multi-channel NCO clock-enable/square-wave generator with
// PLL lock qualification. Optional build macro NCO_PHASE_SYNC_EN adds the
// nco_sync input that zeroes all enabled accumulators in RUN.
module nco_clk_gen
   import nco_clk_gen_pkg::*;
#(
   parameter int unsigned NUM_CH      = 3,
   parameter int unsigned ACC_W       = 32,
   parameter int unsigned LOCK_CNT    = 1024,
   parameter int unsigned SYNC_STAGES = 2,
   localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
   input  logic              refclk,
   input  logic              rst,
   input  logic              pll_locked,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]  cfg_inc,
   input  logic [NUM_CH-1:0] ch_en,
`ifdef NCO_PHASE_SYNC_EN
   input  logic              nco_sync,
`endif
   output logic [NUM_CH-1:0] outclk_tick,
   output logic [NUM_CH-1:0] outclk_sq,
   output logic              locked
);

   localparam int unsigned CNT_W = $clog2(LOCK_CNT);

   nco_state_t             state;
   nco_state_t             next_state;
   logic [CNT_W-1:0]       cnt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   pl_s;
   logic                   run;
   logic                   sync_pulse;
   logic [NUM_CH-1:0]      wr;
   logic [NUM_CH-1:0]      pending;

   assign pl_s = sync_q[SYNC_STAGES-1];
   // A RUN cycle with lock already gone counts as leaving RUN, so the
   // accumulators clear on the same edge that drops locked.
   assign run  = (state == RUN) && pl_s;

`ifdef NCO_PHASE_SYNC_EN
   assign sync_pulse = nco_sync;
`else
   assign sync_pulse = 1'b0;
`endif

   // Synchronise the asynchronous PLL lock flag
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      end
   end

   // Lock FSM state, qualification counter and registered locked flag
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state  <= UNLOCKED;
         cnt    <= '0;
         locked <= 1'b0;
      end else begin
         state  <= next_state;
         locked <= (next_state == RUN);
         if ((state == QUALIFY) && pl_s) begin
            cnt <= cnt + CNT_W'(1);
         end else begin
            cnt <= '0;
         end
      end
   end

   // Lock FSM next-state logic
   always_comb begin
      next_state = state;
      case (state)
         UNLOCKED: if (pl_s) next_state = QUALIFY;
         QUALIFY: begin
            if (!pl_s) begin
               next_state = UNLOCKED;
            end else if (cnt == CNT_W'(LOCK_CNT - 1)) begin
               next_state = RUN;
            end
         end
         RUN:      if (!pl_s) next_state = UNLOCKED;
         default:  next_state = UNLOCKED;
      endcase
   end

   // Config decode: ready reflects the addressed channel; out-of-range writes are dropped
   always_comb begin
      cfg_ready = 1'b1;
      wr        = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) begin
            cfg_ready = !pending[i];
            wr[i]     = cfg_valid & !pending[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      nco_channel #(
         .ACC_W (ACC_W)
      ) u_ch (
         .clk     (refclk),
         .rst     (rst),
         .run     (run),
         .en      (ch_en[g]),
         .sync    (sync_pulse),
         .wr      (wr[g]),
         .wr_inc  (cfg_inc),
         .pending (pending[g]),
         .tick    (outclk_tick[g]),
         .sq      (outclk_sq[g])
      );
   end

endmodule

// File: tb/tb_nco_clk_gen.sv
// tb_nco_clk_gen: self-checking bench for nco_clk_gen (NUM_CH=3, ACC_W=8,
// LOCK_CNT=16). Honours NCO_PHASE_SYNC_EN when the build defines it.
`timescale 1ns/1ps
module tb_nco_clk_gen;
   import nco_clk_gen_pkg::*;

   localparam int unsigned N  = 3;
   localparam int unsigned W  = 8;
   localparam int unsigned LC = 16;
   localparam int unsigned S  = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         pll_locked;
   logic         cfg_valid;
   logic         cfg_ready;
   logic [1:0]   cfg_ch;
   logic [W-1:0] cfg_inc;
   logic [N-1:0] ch_en;
   logic [N-1:0] outclk_tick;
   logic [N-1:0] outclk_sq;
   logic         locked;
`ifdef NCO_PHASE_SYNC_EN
   logic         nco_sync;
`endif

   always #5 clk = ~clk;

   nco_clk_gen #(
      .NUM_CH      (N),
      .ACC_W       (W),
      .LOCK_CNT    (LC),
      .SYNC_STAGES (S)
   ) dut (
      .refclk      (clk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_ch      (cfg_ch),
      .cfg_inc     (cfg_inc),
      .ch_en       (ch_en),
`ifdef NCO_PHASE_SYNC_EN
      .nco_sync    (nco_sync),
`endif
      .outclk_tick (outclk_tick),
      .outclk_sq   (outclk_sq),
      .locked      (locked)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: lock = run of consecutive synchronised-high samples,
   // channels = modular sums with carry = (sum >= 2^W).
   bit plq[$];
   int streak;
   bit m_locked;
   int m_acc[N];
   int m_act[N];
   int m_shd[N];
   bit m_pend[N];
   bit m_tick[N];
   bit m_wr_fired;

   typedef struct {
      int           ch;
      logic [W-1:0] inc;
      int           gap;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   task automatic model_reset();
      plq.delete();
      for (int i = 0; i < int'(S); i++) plq.push_back(1'b0);
      streak   = 0;
      m_locked = 1'b0;
      for (int c = 0; c < int'(N); c++) begin
         m_acc[c] = 0; m_act[c] = 0; m_shd[c] = 0; m_pend[c] = 1'b0; m_tick[c] = 1'b0;
      end
      m_wr_fired = 1'b0;
   endtask

   function automatic bit model_ready();
      if (int'(cfg_ch) >= int'(N)) return 1'b1;
      return !m_pend[cfg_ch];
   endfunction

   task automatic model_edge();
      bit pls, run_e, wr, carry, sy;
      int sum, wch;
`ifdef NCO_PHASE_SYNC_EN
      sy = nco_sync;
`else
      sy = 1'b0;
`endif
      pls   = plq.pop_front();
      plq.push_back(pll_locked);
      run_e = m_locked && pls;
      wr    = cfg_valid && model_ready();
      wch   = int'(cfg_ch);
      for (int c = 0; c < int'(N); c++) begin
         if (run_e && ch_en[c]) begin
            sum   = m_acc[c] + m_act[c];
            carry = (sum >= (1 << W));
            if (sy) begin
               m_acc[c]  = 0;
               m_tick[c] = 1'b0;
            end else begin
               m_acc[c]  = sum % (1 << W);
               m_tick[c] = carry;
            end
            if (m_pend[c] && carry) begin
               m_act[c] = m_shd[c]; m_pend[c] = 1'b0;
            end
         end else begin
            if (!run_e) m_acc[c] = 0;
            m_tick[c] = 1'b0;
            if (m_pend[c]) begin
               m_act[c] = m_shd[c]; m_pend[c] = 1'b0;
            end
         end
      end
      if (wr) begin
         m_shd[wch]  = int'(cfg_inc);
         m_pend[wch] = 1'b1;
      end
      m_wr_fired = wr;
      streak   = pls ? streak + 1 : 0;
      m_locked = (streak > int'(LC));
   endtask

   task automatic compare_outputs();
      logic [N-1:0] et, es;
      for (int c = 0; c < int'(N); c++) begin
         et[c] = m_tick[c];
         es[c] = ((m_acc[c] >> (W - 1)) & 1) != 0;
      end
      chk("locked", 64'(locked), 64'(m_locked));
      chk("outclk_tick", 64'(outclk_tick), 64'(et));
      chk("outclk_sq", 64'(outclk_sq), 64'(es));
   endtask

   task automatic step();
      @(negedge clk);
      chk("cfg_ready", 64'(cfg_ready), 64'(model_ready()));
      @(posedge clk);
      model_edge();
      #1;
      compare_outputs();
   endtask

   task automatic write_inc(input int ch, input logic [W-1:0] v);
      int n;
      n = 0;
      cfg_valid = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_inc   = v;
      do begin
         step();
         n++;
      end while (!m_wr_fired && n < 600);
      cfg_valid = 1'b0;
      if (!m_wr_fired) timeout_fail("write_accept");
   endtask

   task automatic program_ch(input int ch, input logic [W-1:0] v);
      ch_en[ch] = 1'b0;
      write_inc(ch, v);
      step();
      step();
      ch_en[ch] = 1'b1;
   endtask

   task automatic measure_gap(input int ch, output int gap);
      int n;
      gap = -1;
      n = 0;
      while (!outclk_tick[ch] && n < 300) begin step(); n++; end
      if (outclk_tick[ch]) begin
         n = 0;
         do begin step(); n++; end while (!outclk_tick[ch] && n < 300);
         if (outclk_tick[ch]) gap = n;
      end
   endtask

   task automatic wait_locked(input string name);
      int n;
      n = 0;
      while (!locked && n < 200) begin step(); n++; end
      if (!locked) timeout_fail(name);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl[7];
      int n, gap, t, drop, k;

      tbl[0] = '{0, 8'h40, 4};
      tbl[1] = '{0, 8'h80, 2};
      tbl[2] = '{1, 8'h10, 16};
      tbl[3] = '{2, 8'h20, 8};
      tbl[4] = '{2, 8'h01, 256};
      tbl[5] = '{1, 8'h08, 32};
      tbl[6] = '{0, 8'h00, -1};

      rst = 1'b1; pll_locked = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0; ch_en = '1;
`ifdef NCO_PHASE_SYNC_EN
      nco_sync = 1'b0;
`endif
      model_reset();
      #2;
      chk("reset_locked", 64'(locked), 64'd0);
      chk("reset_tick", 64'(outclk_tick), 64'd0);
      chk("reset_sq", 64'(outclk_sq), 64'd0);
      chk("reset_ready", 64'(cfg_ready), 64'd1);
      chk("inc_for_hz", inc_for_hz(25.0e6, 100.0e6, W), 64'd64);
      #5 rst = 1'b0;

      // Qualification interrupted after ~10 cycles, then clean requalification
      pll_locked = 1'b1;
      repeat (12) begin step(); chk("qualify_no_lock", 64'(locked), 64'd0); end
      pll_locked = 1'b0;
      repeat (3) begin step(); chk("drop_no_lock", 64'(locked), 64'd0); end
      pll_locked = 1'b1;
      step();
      n = 0;
      while (!locked && n < 100) begin step(); n++; end
      chk("lock_latency", 64'(n), 64'(S + LC));

      // Frequency table, programmed with the channel paused
      foreach (tbl[i]) begin
         program_ch(tbl[i].ch, tbl[i].inc);
         measure_gap(tbl[i].ch, gap);
         chk($sformatf("tick_gap_ch%0d_inc%0h", tbl[i].ch, tbl[i].inc), 64'(gap), 64'(tbl[i].gap));
      end

      // Glitch-free retune on channel 1: 0x10 -> 0x40 written mid-period
      program_ch(1, 8'h10);
      n = 0;
      while (!outclk_tick[1] && n < 40) begin step(); n++; end
      if (!outclk_tick[1]) timeout_fail("retune_first_tick");
      t = 0;
      repeat (5) begin step(); t++; end
      cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_inc = 8'h40;
      step(); t++;
      cfg_valid = 1'b0;
      while (!outclk_tick[1] && t < 40) begin
         chk("retune_ready_low", 64'(cfg_ready), 64'd0);
         step(); t++;
      end
      chk("retune_old_period", 64'(t), 64'd16);
      chk("retune_ready_back", 64'(cfg_ready), 64'd1);
      repeat (2) begin
         n = 0;
         do begin step(); n++; end while (!outclk_tick[1] && n < 40);
         chk("retune_new_period", 64'(n), 64'd4);
      end

      // Channel 2 paused for 5 cycles, then resumes from its held phase
      program_ch(2, 8'h30);
      repeat (7) step();
      ch_en[2] = 1'b0;
      repeat (5) begin step(); chk("disabled_tick", 64'(outclk_tick[2]), 64'd0); end
      ch_en[2] = 1'b1;
      repeat (20) step();

      // Write to a non-existent channel is accepted and ignored
      cfg_valid = 1'b1; cfg_ch = 2'(N); cfg_inc = 8'h77;
      step();
      chk("invalid_ch_ready", 64'(cfg_ready), 64'd1);
      cfg_valid = 1'b0;
      for (int c = 0; c < int'(N); c++) begin
         cfg_ch = 2'(c);
         step();
         chk($sformatf("invalid_no_pending_ch%0d", c), 64'(cfg_ready), 64'd1);
      end

      // Lock loss: locked and accumulators clear after the synchroniser delay
      pll_locked = 1'b0;
      n = 0;
      do begin step(); n++; end while (locked && n < 10);
      chk("lockloss_latency", 64'(n), 64'(S + 1));
      chk("lockloss_sq", 64'(outclk_sq), 64'd0);
      repeat (30) begin step(); chk("lockloss_no_tick", 64'(outclk_tick), 64'd0); end
      pll_locked = 1'b1;
      wait_locked("relock");

      // Randomised traffic against the model
      drop = 0;
      for (int i = 0; i < 3000; i++) begin
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_ch    = 2'($urandom_range(0, 3));
         cfg_inc   = W'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            k = $urandom_range(0, N - 1);
            ch_en[k] = ~ch_en[k];
         end
         if (drop > 0) begin
            pll_locked = 1'b0;
            drop--;
         end else begin
            pll_locked = 1'b1;
            if ($urandom_range(0, 399) == 0) drop = $urandom_range(1, 6);
         end
`ifdef NCO_PHASE_SYNC_EN
         nco_sync = ($urandom_range(0, 63) == 0);
`endif
         step();
      end
      cfg_valid = 1'b0;
      ch_en = '1;
      pll_locked = 1'b1;
`ifdef NCO_PHASE_SYNC_EN
      nco_sync = 1'b0;
`endif
      repeat (4) step();

      // Asynchronous reset mid-operation
      rst = 1'b1;
      #1;
      chk("midreset_locked", 64'(locked), 64'd0);
      chk("midreset_tick", 64'(outclk_tick), 64'd0);
      chk("midreset_sq", 64'(outclk_sq), 64'd0);
      chk("midreset_ready", 64'(cfg_ready), 64'd1);
      model_reset();
      #1 rst = 1'b0;
      wait_locked("post_reset_lock");
      program_ch(0, 8'h40);
      measure_gap(0, gap);
      chk("post_reset_gap", 64'(gap), 64'd4);

`ifdef NCO_PHASE_SYNC_EN
      // Phase sync: equal increments tick together afterwards
      program_ch(0, 8'h20);
      step();
      program_ch(2, 8'h20);
      repeat (3) step();
      nco_sync = 1'b1;
      step();
      nco_sync = 1'b0;
      chk("sync_sq_zero", 64'(outclk_sq), 64'd0);
      repeat (40) begin
         step();
         chk("sync_aligned", 64'(outclk_tick[2]), 64'(m_tick[0]));
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
